ram_burst_master: RTL and testbench

Burst initiator that drives one read/write port of the flip-flop RAM (`en`/`rw_`/`addr`/`wdata`/`rdata` port convention). It accepts one burst request at a time on a valid/ready command interface. It streams write data from a valid/ready source into sequential RAM addresses, or streams read data from sequential RAM addresses to a valid/ready sink with full backpressure. It sits between DMA/stream logic and the RAM, and hides the RAM's output-register option behind a fixed handshake.

---
 rtl/ram_burst_pkg.sv | 16 +
 rtl/ram_rd_buf.sv | 61 ++++++
 rtl/ram_burst_master.sv | 171 +++++++++++++++++
 tb/tb_ram_burst_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst master and its read buffer.
package ram_burst_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Encoding of the RAM port rw_ line and of req_rw_.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ram_rd_buf.sv
// Two-entry synchronous FIFO that decouples RAM read data from the rd sink.
// A push and a pop may happen in the same cycle, also when the FIFO is full.
module ram_rd_buf #(
  parameter int DATA = 16
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            push,
  input  logic            pop,
  input  logic [DATA-1:0] wdata,
  output logic [DATA-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic [1:0]      count
);

  logic [DATA-1:0] mem_q [2];
  logic [DATA-1:0] mem_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next storage/pointer values from this cycle's push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Storage and pointers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for one port of the flip-flop RAM.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// WRITE | one RAM write per accepted wr beat
// READ  | issuing RAM reads while buffer + in-flight leaves room
// DRAIN | all reads issued, waiting for the sink to take the rest
// DONE  | one-cycle done pulse
//
// The read buffer holds at most two beats; reads are issued only when
// buffered + in-flight beats, after this cycle's pop, stay below two, so
// the buffer can never overflow regardless of rd_ready.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter  int DATA   = 16,
  parameter  int DEPTH  = 4,
  parameter  int MAXLEN = 8,
  parameter  int RD_LAT = 0,
  localparam int ADDR   = $clog2(DEPTH),
  localparam int LENW   = $clog2(MAXLEN + 1)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_rw_,
  input  logic [ADDR-1:0] req_addr,
  input  logic [LENW-1:0] req_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DATA-1:0] wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic            done,
  output logic            ram_en,
  output logic            ram_rw_,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_wdata,
  input  logic [DATA-1:0] ram_rdata
);

  state_e          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d, addr_nxt;
  logic [LENW-1:0] rem_q, rem_d;
  logic            inflight_q, inflight_d;

  logic            wr_beat, rd_issue;
  logic            buf_push, buf_pop, buf_full, buf_empty;
  logic [1:0]      buf_count;
  logic [DATA-1:0] buf_head;
  logic [2:0]      occ;

  // Outputs are forced low while reset_ is asserted, before the first edge.
  assign addr_nxt = (addr_q == ADDR'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
  assign buf_push = (RD_LAT == 0) ? rd_issue : inflight_q;
  assign rd_valid = reset_ && !buf_empty;
  assign rd_data  = reset_ ? buf_head : '0;

  ram_rd_buf #(.DATA(DATA)) u_rd_buf (
    .clk    (clk),
    .reset_ (reset_),
    .push   (buf_push),
    .pop    (buf_pop),
    .wdata  (ram_rdata),
    .rdata  (buf_head),
    .full   (buf_full),
    .empty  (buf_empty),
    .count  (buf_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Address, remaining-beat down-counter and read in-flight flag.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = (RD_LAT != 0) && rd_issue;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          rem_d  = req_len;
          if (req_len == '0)            state_d = DONE;
          else if (req_rw_ == RW_READ)  state_d = READ;
          else                          state_d = WRITE;
        end
      end
      WRITE: begin
        if (wr_beat) begin
          addr_d = addr_nxt;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LENW'(1)) state_d = DONE;
        end
      end
      READ: begin
        if (rd_issue) begin
          addr_d = addr_nxt;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LENW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as this cycle's pop empties the buffer, so done
        // follows the last rd handshake by exactly one cycle.
        if (!inflight_q && (buf_count == {1'b0, buf_pop})) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshakes and RAM port drive for the current state.
  always_comb begin
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    ram_en    = 1'b0;
    ram_rw_   = RW_WRITE;
    ram_addr  = '0;
    ram_wdata = '0;
    wr_beat   = 1'b0;
    rd_issue  = 1'b0;
    buf_pop   = reset_ && !buf_empty && rd_ready;
    occ       = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, buf_pop};
    if (reset_) begin
      unique case (state_q)
        IDLE:  req_ready = 1'b1;
        WRITE: begin
          wr_ready = 1'b1;
          wr_beat  = wr_valid;
          if (wr_valid) begin
            ram_en    = 1'b1;
            ram_addr  = addr_q;
            ram_wdata = wr_data;
          end
        end
        READ: begin
          rd_issue = (occ < 3'd2) && !(buf_full && !buf_pop);
          if (rd_issue) begin
            ram_en   = 1'b1;
            ram_rw_  = RW_READ;
            ram_addr = addr_q;
          end
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: two instances (RD_LAT 0 and 1), each with its
// own RAM model, driven by a burst table, a reset-abort sequence and random
// bursts. Expected data comes from a shadow memory the bench maintains.
module tb_ram_burst_master;

  logic        clk = 1'b0;
  logic        reset_n   [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_rw_   [2];
  logic [1:0]  req_addr  [2];
  logic [3:0]  req_len   [2];
  logic        wr_valid  [2];
  logic        wr_ready  [2];
  logic [15:0] wr_data   [2];
  logic        rd_valid  [2];
  logic        rd_ready  [2];
  logic [15:0] rd_data   [2];
  logic        done      [2];
  logic        ram_en    [2];
  logic        ram_rw_   [2];
  logic [1:0]  ram_addr  [2];
  logic [15:0] ram_wdata [2];
  logic [15:0] ram_rdata [2];

  logic [15:0] shadow [2][4];
  int n_cmp = 0;
  int n_bad = 0;
  int cur_d = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] mem [4];
    logic [15:0] rq;

    ram_burst_master #(.DATA(16), .DEPTH(4), .MAXLEN(8), .RD_LAT(g)) u_dut (
      .clk       (clk),
      .reset_    (reset_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_rw_   (req_rw_[g]),
      .req_addr  (req_addr[g]),
      .req_len   (req_len[g]),
      .wr_valid  (wr_valid[g]),
      .wr_ready  (wr_ready[g]),
      .wr_data   (wr_data[g]),
      .rd_valid  (rd_valid[g]),
      .rd_ready  (rd_ready[g]),
      .rd_data   (rd_data[g]),
      .done      (done[g]),
      .ram_en    (ram_en[g]),
      .ram_rw_   (ram_rw_[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g])
    );

    initial begin
      for (int i = 0; i < 4; i++) mem[i] = 16'h0;
      rq = 16'h0;
    end

    always @(posedge clk) begin
      if (ram_en[g] && !ram_rw_[g]) mem[ram_addr[g]] <= ram_wdata[g];
      if (ram_en[g] &&  ram_rw_[g]) rq <= mem[ram_addr[g]];
    end

    assign ram_rdata[g] = (g == 0) ? mem[ram_addr[g]] : rq;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h want %0h", nm, cur_d, $time, act, exp);
    end
  endtask

  // Runs one burst on instance d. pat/patlen give the wr_valid (write) or
  // rd_ready (read) pattern per cycle after accept; mode 1 randomizes it.
  task automatic run_burst(input int d, input logic rw, input int a, input int len,
                           input int mode, input logic [7:0] pat, input int patlen,
                           input int exp_done);
    int beats = 0, issued = 0, popped = 0, first_v = -1, done_c = -1;
    logic stalled = 1'b0, drv, steady;
    logic [15:0] hold = 16'h0;
    cur_d  = d;
    steady = (mode == 0) && (patlen == 1) && pat[0];
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_rw_[d] = rw; req_addr[d] = 2'(a); req_len[d] = 4'(len);
    @(negedge clk);
    chk("req_ready", req_ready[d], 1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      drv = (mode == 1) ? 1'($urandom_range(0, 1)) : pat[(c - 1) % patlen];
      wr_data[d] = 16'($urandom);
      if (!rw) begin
        wr_valid[d] = drv; rd_ready[d] = 1'b0;
      end else begin
        wr_valid[d] = 1'($urandom_range(0, 1)); rd_ready[d] = drv;
      end
      @(negedge clk);
      if (ram_en[d]) chk("beat_count", (rw ? issued : beats) < len, 1);
      if (!rw) begin
        if (beats < len) begin
          chk("wr_ready", wr_ready[d], 1);
          chk("wr_en_follow", ram_en[d], wr_valid[d]);
        end else begin
          chk("wr_ready_after", wr_ready[d], 0);
        end
        if (ram_en[d]) begin
          chk("wr_addr", ram_addr[d], (a + beats) % 4);
          chk("wr_rw", ram_rw_[d], 0);
          chk("wr_wdata", ram_wdata[d], wr_data[d]);
          shadow[d][(a + beats) % 4] = wr_data[d];
          beats++;
        end
      end else begin
        chk("rd_wr_ready", wr_ready[d], 0);
        if (ram_en[d]) begin
          chk("rd_addr", ram_addr[d], (a + issued) % 4);
          chk("rd_rw", ram_rw_[d], 1);
          issued++;
        end
        if (steady) chk("rd_issue", ram_en[d], c <= len);
        if (stalled) begin
          chk("rd_hold_valid", rd_valid[d], 1);
          chk("rd_hold_data", rd_data[d], hold);
        end
        if (rd_valid[d] && first_v < 0) first_v = c;
        if (rd_valid[d] && rd_ready[d]) begin
          chk("rd_data", rd_data[d], shadow[d][(a + popped) % 4]);
          popped++;
        end
        stalled = rd_valid[d] && !rd_ready[d];
        hold    = rd_data[d];
        chk("outstanding", (issued - popped) <= 2, 1);
      end
      if (done[d]) begin
        done_c = c;
        chk("done_no_access", ram_en[d], 0);
        break;
      end
      @(posedge clk); #1;
    end
    if (done_c < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout dut%0d: got no done want done within 300 cycles", d);
    end
    if (exp_done >= 0) chk("done_lat", done_c, exp_done);
    chk("beats", rw ? popped : beats, len);
    if (rw && steady && len > 0) chk("first_rd_valid", first_v, 2 + d);
    @(posedge clk); #1;
    wr_valid[d] = 1'b0; rd_ready[d] = 1'b0;
    @(negedge clk);
    chk("done_pulse", done[d], 0);
    chk("idle_ready", req_ready[d], 1);
  endtask

  // Reset asserted during the third issue of a len=6 read, then a fresh burst.
  task automatic reset_mid(input int d);
    cur_d = d;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_rw_[d] = 1'b1; req_addr[d] = 2'd0; req_len[d] = 4'd6;
    @(negedge clk);
    chk("rst_req_ready", req_ready[d], 1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0; rd_ready[d] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    reset_n[d] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rd_valid", rd_valid[d], 0);
    chk("rst_ram_en", ram_en[d], 0);
    chk("rst_done", done[d], 0);
    chk("rst_req_ready_low", req_ready[d], 0);
    @(posedge clk); #1;
    reset_n[d] = 1'b1; rd_ready[d] = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready[d], 1);
    chk("post_rst_rd_valid", rd_valid[d], 0);
    chk("post_rst_ram_en", ram_en[d], 0);
    chk("post_rst_done", done[d], 0);
    run_burst(d, 1'b0, 0, 4, 0, 8'h01, 1, 5);
    run_burst(d, 1'b1, 0, 4, 0, 8'h01, 1, 6 + d);
  endtask

  typedef struct {
    logic       rw;
    int         addr;
    int         len;
    logic [7:0] pat;
    int         patlen;
    int         exp_done0;
    int         exp_done1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 2, 4, 8'h01,      1,  5,  5};
    tbl[1] = '{1'b1, 2, 4, 8'h01,      1,  6,  7};
    tbl[2] = '{1'b1, 0, 8, 8'b1001,    4, -1, -1};
    tbl[3] = '{1'b0, 1, 4, 8'b101101,  6,  7,  7};
    tbl[4] = '{1'b0, 3, 0, 8'h01,      1,  1,  1};
    tbl[5] = '{1'b1, 3, 0, 8'h01,      1,  1,  1};
    tbl[6] = '{1'b1, 3, 1, 8'h01,      1,  3,  4};
    tbl[7] = '{1'b0, 3, 8, 8'h01,      1,  9,  9};
    tbl[8] = '{1'b1, 1, 8, 8'h01,      1, 10, 11};

    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0; req_valid[d] = 1'b0; req_rw_[d] = 1'b0;
      req_addr[d] = 2'd0; req_len[d] = 4'd0; wr_valid[d] = 1'b0;
      wr_data[d] = 16'hFFFF; rd_ready[d] = 1'b0;
      for (int i = 0; i < 4; i++) shadow[d][i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cur_d = d;
      chk("reset_req_ready", req_ready[d], 0);
      chk("reset_wr_ready", wr_ready[d], 0);
      chk("reset_rd_valid", rd_valid[d], 0);
      chk("reset_done", done[d], 0);
      chk("reset_ram_en", ram_en[d], 0);
      chk("reset_rd_data", rd_data[d], 0);
      chk("reset_ram_addr", ram_addr[d], 0);
      chk("reset_ram_wdata", ram_wdata[d], 0);
    end
    @(posedge clk); #1;
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        run_burst(d, tbl[i].rw, tbl[i].addr, tbl[i].len, 0, tbl[i].pat,
                  tbl[i].patlen, (d == 0) ? tbl[i].exp_done0 : tbl[i].exp_done1);
      end
      reset_mid(d);
      for (int i = 0; i < 25; i++) begin
        run_burst(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 8)), 1, 8'h01, 1, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
